// File: rtl/temp_display_scan_if.sv
// Bundle between the temperature source and the display scanner:
// load request/status in one direction, decoder digit code and anodes in the other.
interface temp_display_scan_if;
  logic [10:0] temp_bin;
  logic        temp_valid;
  logic        busy;
  logic        conv_done;
  logic [3:0]  bcd;
  logic [3:0]  an;

  modport master (
    output temp_bin, temp_valid,
    input  busy, conv_done, bcd, an
  );

  modport slave (
    input  temp_bin, temp_valid,
    output busy, conv_done, bcd, an
  );
endinterface

// File: rtl/temp_display_scan.sv
// Signed binary temperature -> sign/hundreds/tens/ones via one-shift-per-clock
// double-dabble, committed atomically and scanned onto a 4-digit common-anode display.
module temp_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  temp_display_scan_if.slave io
);

  localparam int CW = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [3:0] BLANK = 4'd10;
  localparam logic [3:0] MINUS = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] val_q, val_d;
  logic        ovr_q, ovr_d;
  logic [9:0]  mag_q, mag_d;
  logic [11:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  digit_q [4];
  logic [3:0]  digit_d [4];
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [1:0]  idx_q, idx_d;

  logic signed [10:0] val_s;
  logic [11:0] acc_adj;
  logic [3:0]  hund, tens, ones;

  assign val_s = val_q;
  assign hund  = acc_q[11:8];
  assign tens  = acc_q[7:4];
  assign ones  = acc_q[3:0];

  // Double-dabble correction applied to every BCD nibble before each shift
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                  acc_q[gi*4 +: 4] + 4'd3 : acc_q[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    ovr_d   = ovr_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];

    unique case (state_q)
      IDLE: begin
        if (io.temp_valid) begin
          val_d   = io.temp_bin;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (val_s > 11'sd999 || val_s < -11'sd999) begin
          ovr_d   = 1'b1;
          state_d = DONE;
        end else begin
          ovr_d   = 1'b0;
          // Low 10 bits of the negation are exact because |value| <= 999
          mag_d   = val_q[10] ? (~val_q[9:0] + 10'd1) : val_q[9:0];
          acc_d   = 12'd0;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = (acc_adj << 1) | {11'd0, mag_q[9]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = DONE;
      end
      DONE: begin
        if (ovr_q) begin
          for (int i = 0; i < 4; i++) digit_d[i] = MINUS;
        end else begin
          digit_d[3] = val_q[10] ? MINUS : BLANK;
          digit_d[2] = (hund == 4'd0) ? BLANK : hund;
          digit_d[1] = (hund == 4'd0 && tens == 4'd0) ? BLANK : tens;
          digit_d[0] = ones;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running scan, independent of the conversion FSM
  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (rcnt_q == CW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      ovr_q   <= 1'b0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) digit_q[i] <= BLANK;
      rcnt_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      ovr_q   <= ovr_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
    end
  end

  assign io.busy      = (state_q != IDLE);
  assign io.conv_done = (state_q == DONE);
  assign io.an        = ~(4'b0001 << idx_q);
  assign io.bcd       = digit_q[idx_q];

endmodule
